uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART_Tx instance among N byte-producing requesters.
- Accepts one byte per frame through a valid/ready handshake.
- Pulses the transmitter's start with the latched byte.
- Holds off further grants until the frame has fully left the line. UART_Tx exposes no busy/done, so frame time comes from an internal timer.
- Sits between the system's byte sources and the start/data inputs of UART_Tx.

Parameters:
N, 4, number of requesters (2..8)
CLKS_PER_BIT, 16, clock cycles per UART bit; must match the transmitter's baud divider
FRAME_BITS, 10, bits per frame (start + 8 data + stop)
GUARD_CYCLES, 2, extra idle-line cycles after each frame before the next launch

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  N  requester i has a byte on req_data[8i+7:8i]
req_data  input  8*N  concatenated request bytes, requester 0 in bits [7:0]
req_ready  output  N  one-hot accept strobe; a byte transfers when req_valid[i] & req_ready[i] at a clock edge
tx_start  output  1  one-cycle start pulse to UART_Tx
tx_data  output  8  byte to UART_Tx, stable from launch through end of frame
grant_id  output  clog2(N) (min 1)  index of requester owning the current frame
busy  output  1  high in LAUNCH and WAIT states

Behaviour:
- Reset (async, immediate): state IDLE, req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, busy=0, round-robin pointer=0, wait counter=0. Reset mid-frame abandons the frame. UART_Tx shares the same reset, so the line returns idle.
- States: IDLE -> LAUNCH -> WAIT -> IDLE.
- IDLE:
  - req_ready is combinational: one-hot to the first requester with req_valid=1, scanning from pointer upward with wrap (pointer, pointer+1, ..., N-1, 0, ...). All zero if no valid.
  - On an edge with any valid: latch winner's byte into tx_data, grant_id=winner, pointer=(winner+1) mod N, go to LAUNCH.
- LAUNCH (1 cycle): tx_start=1 (registered output), req_ready=0. Go to WAIT with counter loaded to W-1, where W = CLKS_PER_BIT*FRAME_BITS + GUARD_CYCLES.
- WAIT: tx_start=0, req_ready=0. Counter decrements each cycle. At 0, go to IDLE.
- Timing:
  - The accept edge starts the frame. tx_start is high in the next cycle.
  - busy is high for exactly 1+W cycles.
  - With continuous demand, accept edges are 2+W cycles apart. Defaults: W=162, period 164 cycles.
- Handshake rules:
  - Requesters may raise or drop req_valid at any time.
  - Ungranted requests are not remembered; no request is lost once accepted.
  - req_data is sampled only at the accept edge.
- Fairness: a requester that holds valid is granted within N frames.
- Single active requester: granted every frame regardless of pointer.
- Simultaneous requests in one cycle: exactly one grant, the lowest index at or after pointer.
- tx_data and grant_id hold their last values through IDLE until the next accept.
- Counter width: clog2(W)+1 bits. W>=2 is guaranteed by the parameter ranges.

Test Plan:
- Reset then idle, all req_valid=0 for 500 cycles -> req_ready=0, tx_start never pulses, busy=0, tx_data=00.
- Single frame: req_valid=4'b0001, req_data[7:0]=A5 -> req_ready[0] high 1 cycle; tx_start high next cycle with tx_data=A5; busy high 163 cycles; the UART_Rx loopback reports rx_data=A5 with done.
- All four requesters valid continuously, data 11/22/33/44 -> grants in order 0,1,2,3,0 with accept edges exactly 164 cycles apart; each byte received intact and in that order.
- Requester 2 only, held valid, 3 frames -> three grants to id 2 at 164-cycle spacing. Then requester 1 raises valid -> next grant goes to 1's turn per pointer (pointer=3 -> scan 3,0,1 -> grant 1).
- Requester 0 drops valid before its turn while 1 waits -> no grant to 0; requester 1 granted; no spurious tx_start.
- Assert reset 50 cycles into WAIT -> busy=0, tx_start=0, tx_data=00, pointer=0 immediately. After release with req_valid=4'b1010 -> first grant to 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin arbiter sharing one UART transmitter among N byte sources.
// Latency : accept edge -> tx_start high the next cycle; next accept no sooner than 2+W cycles later.
// Backpressure: req_ready is offered only in IDLE; requesters hold req_valid until they see their ready.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   req_valid[N]          - requester i has a byte on req_data[8i+7:8i]
//   req_data[8N]          - concatenated request bytes, requester 0 in [7:0]
//   req_ready[N]          - one-hot accept strobe, combinational in IDLE
//   tx_start, tx_data[8]  - start pulse and held byte towards the UART transmitter
//   grant_id              - index of the requester owning the current/last frame
//   busy                  - high while a frame is being launched or timed out
module uart_tx_arbiter #(
    parameter int N            = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int FRAME_BITS   = 10,
    parameter int GUARD_CYCLES = 2,
    localparam int GW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [8*N-1:0]  req_data,
    output logic [N-1:0]    req_ready,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    output logic [GW-1:0]   grant_id,
    output logic            busy
);

    // Frame time plus idle guard; the transmitter gives no done indication.
    localparam int W  = CLKS_PER_BIT * FRAME_BITS + GUARD_CYCLES;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic            busy_q, busy_d;

    // Round-robin search
    logic [2*N-1:0]  dbl_vld;
    logic [N-1:0]    rot_vld;
    logic [N-1:0]    shf_vld;
    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [GW-1:0]   ptr_nxt;
    logic [8*N-1:0]  data_shf;
    logic [7:0]      win_byte;
    int              win_off;
    int              win_sum;
    int              nxt_sum;

    always_comb begin
        // Rotate valids so bit k corresponds to requester (ptr + k) mod N;
        // the lowest set bit is then the next requester in round-robin order.
        dbl_vld   = {req_valid, req_valid};
        rot_vld   = N'(dbl_vld >> ptr_q);
        shf_vld   = '0;
        win_found = 1'b0;
        win_off   = 0;
        for (int k = 0; k < N; k++) begin
            shf_vld = rot_vld >> k;
            if (!win_found && shf_vld[0]) begin
                win_found = 1'b1;
                win_off   = k;
            end
        end
        win_sum = int'(ptr_q) + win_off;
        if (win_sum >= N) begin
            win_sum = win_sum - N;
        end
        win_idx = GW'(win_sum);
        nxt_sum = win_sum + 1;
        if (nxt_sum >= N) begin
            nxt_sum = 0;
        end
        ptr_nxt  = GW'(nxt_sum);
        data_shf = req_data >> {win_idx, 3'b000};
        win_byte = data_shf[7:0];
    end

    // Ready is only offered while idle and never while reset is held.
    assign req_ready = (!reset && (state_q == S_IDLE) && win_found) ? (N'(1) << win_idx) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    tx_data_d  = win_byte;
                    grant_id_d = win_idx;
                    ptr_d      = ptr_nxt;
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = CW'(W - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter runs W-1..0, so WAIT lasts exactly W cycles.
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule
